// File: rtl/ldpc_parity_accum.sv
// Streaming GF(2) parity accumulator for the LDPC encoder: quasi-cyclic rows
// rotate once per accepted beat, and each parity bit accumulates the beat's dot product with its row.
module ldpc_parity_accum #(
  parameter int DATA_W = 8,
  parameter int PAR_W  = 8,
  parameter int BEATS  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [PAR_W*DATA_W-1:0] coef_in,
  input  logic [PAR_W-1:0]        seed_in,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_W-1:0]       s_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [PAR_W-1:0]        m_parity,
  output logic                    busy
);

  localparam int CNT_W = $clog2(BEATS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  // Handshakes: a beat moves on an edge where s_valid && s_ready; the parity
  // word moves on an edge where m_valid && m_ready. Neither ready/valid
  // depends combinationally on its partner.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } state_t;

  state_t                state;
  state_t                next_state;
  logic [CNT_W-1:0]      cnt;
  logic [PAR_W-1:0]      par;
  logic [DATA_W-1:0]     coef [PAR_W];
  logic [PAR_W-1:0]      dot;
  logic                  accept;
  logic                  load;

  assign accept = s_valid && (state == ACCUM);
  assign load   = start && (state == IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; abort overrides every transition
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = ACCUM;
      ACCUM:   if (accept && (cnt == LAST_CNT)) next_state = OUT;
      OUT:     if (m_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (abort) begin
      next_state = IDLE;
    end
  end

  // Output decode from registered state only
  always_comb begin
    s_ready = 1'b0;
    m_valid = 1'b0;
    busy    = 1'b0;
    case (state)
      ACCUM: begin
        s_ready = 1'b1;
        busy    = 1'b1;
      end
      OUT: begin
        m_valid = 1'b1;
        busy    = 1'b1;
      end
      default: ;
    endcase
  end

  // Message bit i pairs with row bit DATA_W-1-i (reversed bit order)
  always_comb begin
    for (int j = 0; j < PAR_W; j++) begin
      dot[j] = 1'b0;
      for (int i = 0; i < DATA_W; i++) begin
        dot[j] = dot[j] ^ (s_data[i] & coef[j][DATA_W-1-i]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      par <= '0;
      for (int j = 0; j < PAR_W; j++) begin
        coef[j] <= '0;
      end
    end else if (abort) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
      par <= seed_in;
      for (int j = 0; j < PAR_W; j++) begin
        coef[j] <= coef_in[j*DATA_W +: DATA_W];
      end
    end else if (accept) begin
      cnt <= cnt + 1'b1;
      par <= par ^ dot;
      for (int j = 0; j < PAR_W; j++) begin
        coef[j] <= {coef[j][DATA_W-2:0], coef[j][DATA_W-1]};
      end
    end
  end

  assign m_parity = par;

endmodule

// File: tb/tb_ldpc_parity_accum.sv
// Directed bench for ldpc_parity_accum (DATA_W=8, PAR_W=2, BEATS=2): a table of
// hand-computed codewords plus sequences for ignored start, abort and async reset.
module tb_ldpc_parity_accum;

  localparam int DATA_W = 8;
  localparam int PAR_W  = 2;
  localparam int BEATS  = 2;

  logic                    clk;
  logic                    rst_n;
  logic                    start;
  logic                    abort;
  logic [PAR_W*DATA_W-1:0] coef_in;
  logic [PAR_W-1:0]        seed_in;
  logic                    s_valid;
  logic                    s_ready;
  logic [DATA_W-1:0]       s_data;
  logic                    m_valid;
  logic                    m_ready;
  logic [PAR_W-1:0]        m_parity;
  logic                    busy;

  int checks = 0;
  int errors = 0;

  ldpc_parity_accum #(.DATA_W(DATA_W), .PAR_W(PAR_W), .BEATS(BEATS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .coef_in(coef_in), .seed_in(seed_in),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_parity(m_parity), .busy(busy)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [PAR_W-1:0]        seed;
    logic [PAR_W*DATA_W-1:0] coef;
    logic [DATA_W-1:0]       b0;
    logic [DATA_W-1:0]       b1;
    int                      gap;
    int                      mwait;
    logic [PAR_W-1:0]        exp_par;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Must be called at a negedge; returns at the negedge after the parity handshake.
  task automatic run_vec(input vec_t v, input string tag);
    start   = 1'b1;
    coef_in = v.coef;
    seed_in = v.seed;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " s_ready after start"}, 32'(s_ready), 32'd1);
    chk({tag, " busy after start"}, 32'(busy), 32'd1);
    s_valid = 1'b1;
    s_data  = v.b0;
    @(negedge clk);
    s_valid = 1'b0;
    s_data  = 8'hFF;
    for (int k = 0; k < v.gap; k++) begin
      @(negedge clk);
      chk({tag, " m_valid during stall"}, 32'(m_valid), 32'd0);
    end
    s_valid = 1'b1;
    s_data  = v.b1;
    @(negedge clk);
    s_valid = 1'b0;
    chk({tag, " m_valid"}, 32'(m_valid), 32'd1);
    chk({tag, " parity"}, 32'(m_parity), 32'(v.exp_par));
    chk({tag, " s_ready in OUT"}, 32'(s_ready), 32'd0);
    for (int k = 0; k < v.mwait; k++) begin
      @(negedge clk);
      chk({tag, " m_valid held"}, 32'(m_valid), 32'd1);
      chk({tag, " parity held"}, 32'(m_parity), 32'(v.exp_par));
      chk({tag, " busy held"}, 32'(busy), 32'd1);
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    chk({tag, " m_valid after handshake"}, 32'(m_valid), 32'd0);
    chk({tag, " busy after handshake"}, 32'(busy), 32'd0);
  endtask

  initial begin
    // seed, coef, beat0, beat1, stall cycles, m_ready-low cycles, expected parity
    vecs[0] = '{2'b00, 16'h01FF, 8'h80, 8'hC0, 0, 0, 2'b01};
    vecs[1] = '{2'b11, 16'h01FF, 8'h80, 8'hC0, 0, 0, 2'b10};
    vecs[2] = '{2'b00, 16'h01FF, 8'h80, 8'hC0, 3, 4, 2'b01};
    vecs[3] = '{2'b00, 16'hAA55, 8'hFF, 8'h01, 1, 1, 2'b01};
    vecs[4] = '{2'b01, 16'h0F03, 8'hC0, 8'h20, 0, 2, 2'b10};

    rst_n   = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    coef_in = '0;
    seed_in = '0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset s_ready", 32'(s_ready), 32'd0);
    chk("reset m_valid", 32'(m_valid), 32'd0);
    chk("reset m_parity", 32'(m_parity), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table vectors run back to back: each start lands in the cycle after the previous handshake
    for (int n = 0; n < 5; n++) begin
      run_vec(vecs[n], $sformatf("vec%0d", n));
    end

    // Beats offered in IDLE are ignored
    s_valid = 1'b1;
    s_data  = 8'h80;
    repeat (3) @(negedge clk);
    s_valid = 1'b0;
    chk("idle beats m_valid", 32'(m_valid), 32'd0);
    chk("idle beats busy", 32'(busy), 32'd0);
    run_vec(vecs[0], "after idle beats");

    // start during ACCUM with other coefficients is ignored
    start = 1'b1; coef_in = 16'h01FF; seed_in = 2'b00;
    @(negedge clk);
    start = 1'b0; s_valid = 1'b1; s_data = 8'h80;
    @(negedge clk);
    s_valid = 1'b0; start = 1'b1; coef_in = 16'hAA55; seed_in = 2'b11;
    @(negedge clk);
    start = 1'b0; s_valid = 1'b1; s_data = 8'hC0;
    @(negedge clk);
    s_valid = 1'b0;
    chk("mid start m_valid", 32'(m_valid), 32'd1);
    chk("mid start parity", 32'(m_parity), 32'd1);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    chk("mid start busy after", 32'(busy), 32'd0);

    // abort after the first beat
    start = 1'b1; coef_in = 16'h01FF; seed_in = 2'b00;
    @(negedge clk);
    start = 1'b0; s_valid = 1'b1; s_data = 8'h80;
    @(negedge clk);
    s_valid = 1'b0; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort s_ready", 32'(s_ready), 32'd0);
    s_valid = 1'b1; s_data = 8'hC0;
    repeat (2) @(negedge clk);
    s_valid = 1'b0;
    chk("abort no m_valid", 32'(m_valid), 32'd0);
    run_vec(vecs[0], "after abort");

    // abort and start together in IDLE: abort wins
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort+start busy", 32'(busy), 32'd0);
    chk("abort+start s_ready", 32'(s_ready), 32'd0);

    // Asynchronous reset between edges mid-ACCUM
    start = 1'b1; coef_in = 16'h01FF; seed_in = 2'b11;
    @(negedge clk);
    start = 1'b0; s_valid = 1'b1; s_data = 8'h80;
    @(negedge clk);
    s_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async rst s_ready", 32'(s_ready), 32'd0);
    chk("async rst m_valid", 32'(m_valid), 32'd0);
    chk("async rst m_parity", 32'(m_parity), 32'd0);
    chk("async rst busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    s_valid = 1'b1; s_data = 8'hC0;
    repeat (3) @(negedge clk);
    s_valid = 1'b0;
    chk("post rst no m_valid", 32'(m_valid), 32'd0);
    chk("post rst busy", 32'(busy), 32'd0);
    run_vec(vecs[0], "after reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
